// File: rtl/dm_byte_if.sv
// Load/store bus between the MIPS datapath and the dm_byte data memory.
// The datapath drives the master side; dm_byte implements the slave side.
interface dm_byte_if;
  logic        MemWrite;
  logic        MemRead;
  logic [1:0]  BEOp;
  logic        LoadSigned;
  logic [31:0] Addr;
  logic [31:0] WD;
  logic [31:0] PC;
  logic [31:0] Dm_out;
  logic        AddrErr;

  modport master (
    output MemWrite, MemRead, BEOp, LoadSigned, Addr, WD, PC,
    input  Dm_out, AddrErr
  );

  modport slave (
    input  MemWrite, MemRead, BEOp, LoadSigned, Addr, WD, PC,
    output Dm_out, AddrErr
  );
endinterface

// File: rtl/dm_byte.sv
// Byte-addressable data memory: word/half/byte loads and stores, zero-latency reads.
// Defining DM_TRACE_EN prints one trace line per committed store.
module dm_byte #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic      clk,
  input  logic      reset,
  dm_byte_if.slave  bus
);

  localparam int          DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [32:0] SPAN  = 33'd4 << DEPTH_LOG2;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  lane_en);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

  logic [31:0]           r_mem [DEPTH];
  logic [31:0]           w_off;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_misalign;
  logic                  w_out_of_range;
  logic                  w_addr_err;
  logic [31:0]           w_word;
  logic [3:0]            w_lane_en;
  logic [31:0]           w_wdata;
  logic [31:0]           w_merged;
  logic [31:0]           w_load;
  logic [15:0]           w_half;
  logic [7:0]            w_byte;

  assign w_off          = bus.Addr - BASE_ADDR;
  assign w_idx          = w_off[DEPTH_LOG2+1:2];
  assign w_out_of_range = (bus.Addr < BASE_ADDR) || ({1'b0, w_off} >= SPAN);
  assign w_word         = r_mem[w_idx];
  assign w_merged       = merge_lanes(w_word, w_wdata, w_lane_en);

  // Alignment check, lane enables and lane-replicated store data per access size
  always_comb begin
    w_misalign = 1'b0;
    w_lane_en  = 4'b1111;
    w_wdata    = bus.WD;
    case (bus.BEOp)
      2'b01: begin
        w_misalign = bus.Addr[0];
        w_lane_en  = bus.Addr[1] ? 4'b1100 : 4'b0011;
        w_wdata    = {bus.WD[15:0], bus.WD[15:0]};
      end
      2'b10: begin
        w_misalign = 1'b0;
        w_lane_en  = 4'b0001 << bus.Addr[1:0];
        w_wdata    = {4{bus.WD[7:0]}};
      end
      default: begin
        w_misalign = (bus.Addr[1:0] != 2'b00);
        w_lane_en  = 4'b1111;
        w_wdata    = bus.WD;
      end
    endcase
  end

  assign w_addr_err = !reset && (bus.MemRead || bus.MemWrite) &&
                      (w_misalign || w_out_of_range);

  // Load lane selection and extension; the result is forced to zero unless a clean load
  always_comb begin
    w_half = bus.Addr[1] ? w_word[31:16] : w_word[15:0];
    w_byte = w_word[{bus.Addr[1:0], 3'b000} +: 8];
    case (bus.BEOp)
      2'b01:   w_load = {{16{bus.LoadSigned & w_half[15]}}, w_half};
      2'b10:   w_load = {{24{bus.LoadSigned & w_byte[7]}}, w_byte};
      default: w_load = w_word;
    endcase
    if (reset || !bus.MemRead || w_addr_err) begin
      bus.Dm_out = 32'h0000_0000;
    end else begin
      bus.Dm_out = w_load;
    end
  end

  assign bus.AddrErr = w_addr_err;

  // Storage: whole-array clear on reset, otherwise lane-merged store commit
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'h0000_0000;
      end
    end else if (bus.MemWrite && !w_addr_err) begin
      r_mem[w_idx] <= w_merged;
`ifdef DM_TRACE_EN
      $display("@%08h: *%08h <= %08h", bus.PC, {bus.Addr[31:2], 2'b00}, w_merged);
`endif
    end
  end

`ifndef DM_TRACE_EN
  logic w_unused_pc;
  assign w_unused_pc = ^bus.PC;
`endif

endmodule

// File: tb/tb_dm_byte.sv
// Self-checking bench for dm_byte: directed vector table, reset sequences,
// and randomized traffic against a byte-array reference model.
module tb_dm_byte;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          BYTES = 4096;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dm_byte_if bus ();

  dm_byte #(.DEPTH_LOG2(10), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we;
    logic        re;
    logic [1:0]  be;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] dout;
    logic        err;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] model [BYTES];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic we, input logic re, input logic [1:0] be,
                       input logic sg, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    reset          = rst;
    bus.MemWrite   = we;
    bus.MemRead    = re;
    bus.BEOp       = be;
    bus.LoadSigned = sg;
    bus.Addr       = addr;
    bus.WD         = wd;
    bus.PC         = 32'h0000_3000;
    #1;
  endtask

  function automatic void add(input logic we, input logic re, input logic [1:0] be, input logic sg,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] dout, input logic err);
    vec_t v;
    v = '{we: we, re: re, be: be, sg: sg, addr: addr, wd: wd, dout: dout, err: err};
    tbl.push_back(v);
  endfunction

  function automatic int size_of(input logic [1:0] be);
    return (be == 2'b01) ? 2 : (be == 2'b10) ? 1 : 4;
  endfunction

  initial begin
    logic [31:0] a, wd, exp_d, v;
    logic        we, re, sg, exp_e, bad_range;
    logic [1:0]  be;
    int          sz, off;

    // Reset sequence: outputs quiet, store during reset dropped, reset clears contents
    drive(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 32'h10, 32'h1234_5678);
    chk("rst_dout", bus.Dm_out, 32'h0);
    chk("rst_err", {31'b0, bus.AddrErr}, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h0);
    chk("rst_err_misal", {31'b0, bus.AddrErr}, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'h0);
    chk("rst_store_dropped", bus.Dm_out, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'hDEAD_BEEF);
    drive(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'h0);
    chk("pre_reset_lw", bus.Dm_out, 32'hDEAD_BEEF);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'h0);
    chk("reset_clears", bus.Dm_out, 32'h0);

    //  we    re    be     sg    addr       wd            dout          err
    add(1'b1, 1'b0, 2'b00, 1'b0, 32'h20,    32'h1122_3344, 32'h0,        1'b0);
    add(1'b1, 1'b0, 2'b10, 1'b0, 32'h21,    32'hFFFF_FFAA, 32'h0,        1'b0);
    add(1'b1, 1'b0, 2'b01, 1'b0, 32'h22,    32'h1234_BBCC, 32'h0,        1'b0);
    add(1'b0, 1'b1, 2'b00, 1'b0, 32'h20,    32'h0,         32'hBBCC_AA44, 1'b0);
    add(1'b0, 1'b1, 2'b10, 1'b0, 32'h21,    32'h0,         32'h0000_00AA, 1'b0);
    add(1'b0, 1'b1, 2'b10, 1'b1, 32'h21,    32'h0,         32'hFFFF_FFAA, 1'b0);
    add(1'b0, 1'b1, 2'b01, 1'b1, 32'h22,    32'h0,         32'hFFFF_BBCC, 1'b0);
    add(1'b0, 1'b1, 2'b01, 1'b0, 32'h22,    32'h0,         32'h0000_BBCC, 1'b0);
    add(1'b0, 1'b1, 2'b11, 1'b0, 32'h20,    32'h0,         32'hBBCC_AA44, 1'b0);
    add(1'b0, 1'b1, 2'b11, 1'b0, 32'h22,    32'h0,         32'h0,         1'b1);
    add(1'b1, 1'b0, 2'b00, 1'b0, 32'h06,    32'h0000_0055, 32'h0,        1'b1);
    add(1'b0, 1'b1, 2'b00, 1'b0, 32'h04,    32'h0,         32'h0,         1'b0);
    add(1'b0, 1'b1, 2'b01, 1'b0, 32'h03,    32'h0,         32'h0,         1'b1);
    add(1'b1, 1'b0, 2'b10, 1'b0, 32'h03,    32'h0000_0077, 32'h0,        1'b0);
    add(1'b0, 1'b1, 2'b10, 1'b0, 32'h03,    32'h0,         32'h0000_0077, 1'b0);
    add(1'b1, 1'b0, 2'b00, 1'b0, 32'h1000,  32'h0000_CAFE, 32'h0,        1'b1);
    add(1'b0, 1'b1, 2'b00, 1'b0, 32'h00,    32'h0,         32'h7700_0000, 1'b0);
    add(1'b1, 1'b0, 2'b00, 1'b0, 32'hFFC,   32'h1234_5678, 32'h0,        1'b0);
    add(1'b0, 1'b1, 2'b00, 1'b0, 32'hFFC,   32'h0,         32'h1234_5678, 1'b0);
    add(1'b0, 1'b1, 2'b00, 1'b0, 32'h1000,  32'h0,         32'h0,         1'b1);
    add(1'b0, 1'b0, 2'b00, 1'b0, 32'h07,    32'h0,         32'h0,         1'b0);
    add(1'b1, 1'b0, 2'b00, 1'b0, 32'h30,    32'h0000_0005, 32'h0,        1'b0);
    add(1'b1, 1'b1, 2'b00, 1'b0, 32'h30,    32'h0000_0009, 32'h0000_0005, 1'b0);
    add(1'b0, 1'b1, 2'b00, 1'b0, 32'h30,    32'h0,         32'h0000_0009, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(1'b0, tbl[i].we, tbl[i].re, tbl[i].be, tbl[i].sg, tbl[i].addr, tbl[i].wd);
      chk($sformatf("vec%0d_dout", i), bus.Dm_out, tbl[i].dout);
      chk($sformatf("vec%0d_err", i), {31'b0, bus.AddrErr}, {31'b0, tbl[i].err});
    end

    // Randomized traffic from a cleared memory against the byte-array model
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < BYTES; i++) model[i] = 8'h00;

    for (int n = 0; n < 400; n++) begin
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      be = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      wd = $urandom;
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = 32'hFF8 + $urandom_range(0, 15);
        default: a = $urandom_range(0, 63);
      endcase
      sz        = size_of(be);
      bad_range = (a < BASE) || ((a - BASE) >= BYTES);
      exp_e     = (we || re) && (((a % sz) != 0) || bad_range);
      exp_d     = 32'h0;
      off       = int'(a - BASE);
      if (re && !exp_e) begin
        v = 32'h0;
        for (int k = 0; k < sz; k++) v = v | (32'(model[off + k]) << (8 * k));
        if (sg && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
        exp_d = v;
      end
      drive(1'b0, we, re, be, sg, a, wd);
      chk($sformatf("rnd%0d_dout", n), bus.Dm_out, exp_d);
      chk($sformatf("rnd%0d_err", n), {31'b0, bus.AddrErr}, {31'b0, exp_e});
      if (we && !exp_e) begin
        for (int k = 0; k < sz; k++) model[off + k] = wd[8*k +: 8];
      end
    end

    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
